// File: rtl/psum_drain_pkg.sv
// Shared definitions for the partial-sum drain path: widths, drain FSM
// state encoding and the signed saturation bounds helper.
package psum_pkg;

    localparam int PSUM_WIDTH = 25;
    localparam int OUT_WIDTH  = 8;
    localparam int PACK       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Upper (upper=1) or lower (upper=0) limit of a signed width-bit integer.
    function automatic logic signed [31:0] sat_bound(input int width, input logic upper);
        logic signed [31:0] mag;
        mag = 32'sd1 <<< (width - 1);
        if (upper) begin
            sat_bound = mag - 32'sd1;
        end else begin
            sat_bound = -mag;
        end
    endfunction

endpackage

// File: rtl/psum_drain_requant.sv
// Two-stage requantiser: bias add, then round-half-up arithmetic shift,
// optional ReLU and saturation to a signed OUT_WIDTH element.
module psum_requant #(
    parameter int DATA_WIDTH  = psum_pkg::PSUM_WIDTH,
    parameter int OUT_WIDTH   = psum_pkg::OUT_WIDTH,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_vld,
    input  logic signed [DATA_WIDTH-1:0] i_psum,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    input  logic [SHIFT_WIDTH-1:0]       i_shift,
    input  logic                         i_relu_en,
    output logic                         o_s1_vld,
    output logic                         o_vld,
    output logic signed [OUT_WIDTH-1:0]  o_data
);
    import psum_pkg::*;

    localparam int S1W = DATA_WIDTH + 1;
    // One extra bit above the bias sum so the rounding increment cannot overflow.
    localparam int RW  = DATA_WIDTH + 2;
    localparam logic signed [RW-1:0]    SAT_HI = RW'(sat_bound(OUT_WIDTH, 1'b1));
    localparam logic signed [RW-1:0]    SAT_LO = RW'(sat_bound(OUT_WIDTH, 1'b0));
    localparam logic signed [RW-1:0]    RW_ONE = RW'(1'b1);
    localparam logic [SHIFT_WIDTH-1:0]  SH_ONE = SHIFT_WIDTH'(1'b1);

    logic signed [S1W-1:0]       r_s1;
    logic                        r_s1_vld;
    logic signed [RW-1:0]        w_ext;
    logic signed [RW-1:0]        w_rnd;
    logic signed [RW-1:0]        w_sum;
    logic signed [RW-1:0]        w_sh;
    logic signed [RW-1:0]        w_rl;
    logic signed [OUT_WIDTH-1:0] w_sat;
    logic signed [OUT_WIDTH-1:0] r_out;
    logic                        r_out_vld;

    // Stage 1: sign-extended bias add.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= i_vld;
            r_s1     <= {i_psum[DATA_WIDTH-1], i_psum} + {i_bias[DATA_WIDTH-1], i_bias};
        end
    end

    // Stage 2 combinational path: round, shift, ReLU, saturate.
    always_comb begin
        w_ext = {r_s1[S1W-1], r_s1};
        if (i_shift != '0) begin
            w_rnd = RW_ONE << (i_shift - SH_ONE);
        end else begin
            w_rnd = '0;
        end
        w_sum = w_ext + w_rnd;
        w_sh  = w_sum >>> i_shift;
        if (i_relu_en && w_sh[RW-1]) begin
            w_rl = '0;
        end else begin
            w_rl = w_sh;
        end
        if (w_rl > SAT_HI) begin
            w_sat = SAT_HI[OUT_WIDTH-1:0];
        end else if (w_rl < SAT_LO) begin
            w_sat = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            w_sat = w_rl[OUT_WIDTH-1:0];
        end
    end

    // Stage 2 result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            r_out_vld <= r_s1_vld;
            r_out     <= w_sat;
        end
    end

    assign o_s1_vld = r_s1_vld;
    assign o_vld    = r_out_vld;
    assign o_data   = r_out;

endmodule

// File: rtl/psum_drain.sv
// Drains a completed tile of partial sums: requantises each one, packs PACK
// int8 results per word and writes them to the OFM SRAM.
module psum_drain #(
    parameter int DATA_WIDTH  = psum_pkg::PSUM_WIDTH,
    parameter int OUT_WIDTH   = psum_pkg::OUT_WIDTH,
    parameter int PACK        = psum_pkg::PACK,
    parameter int ADDR_WIDTH  = 10,
    parameter int CNT_WIDTH   = 12,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          num_elems,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic signed [DATA_WIDTH-1:0]  bias,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic                          relu_en,
    input  logic signed [DATA_WIDTH-1:0]  fifo_out,
    input  logic                          valid_fifo_out,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [PACK*OUT_WIDTH-1:0]     mem_wdata,
    output logic [PACK-1:0]               mem_be,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    import psum_pkg::*;

    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LW-1:0]         LAST_LANE = LW'(PACK - 1);
    localparam logic [LW-1:0]         LANE_ONE  = LW'(1'b1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

    drain_state_t r_state;
    drain_state_t w_next;

    logic [CNT_WIDTH-1:0]         r_num;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic signed [DATA_WIDTH-1:0] r_bias;
    logic [SHIFT_WIDTH-1:0]       r_shift;
    logic                         r_relu;
    logic                         r_err;
    logic                         r_busy;
    logic                         r_done;

    logic [ADDR_WIDTH-1:0]              r_addr;
    logic [LW-1:0]                      r_lane_idx;
    logic [PACK-1:0][OUT_WIDTH-1:0]     r_lanes;
    logic                               r_mem_we;
    logic [ADDR_WIDTH-1:0]              r_mem_addr;
    logic [PACK-1:0][OUT_WIDTH-1:0]     r_mem_wdata;
    logic [PACK-1:0]                    r_mem_be;

    logic                               w_accept;
    logic                               w_last;
    logic                               w_start_ok;
    logic                               w_s1_vld;
    logic                               w_s2_vld;
    logic signed [OUT_WIDTH-1:0]        w_s2_data;
    logic [PACK-1:0][OUT_WIDTH-1:0]     w_lanes;
    logic [PACK-1:0]                    w_be;
    logic                               w_full;
    logic                               w_tail;
    logic                               w_wr;

    assign w_accept   = valid_fifo_out && (r_state == ST_RUN);
    assign w_last     = w_accept && ((r_cnt + CNT_ONE) == r_num);
    assign w_start_ok = start && (r_state == ST_IDLE);

    psum_requant #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (w_accept),
        .i_psum    (fifo_out),
        .i_bias    (r_bias),
        .i_shift   (r_shift),
        .i_relu_en (r_relu),
        .o_s1_vld  (w_s1_vld),
        .o_vld     (w_s2_vld),
        .o_data    (w_s2_data)
    );

    // Drain FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_elems == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_FLUSH;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The tail word is issued as the last element leaves stage 2.
                if (!w_s1_vld && !w_s2_vld) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FLUSH;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_RUN) || (w_next == ST_FLUSH);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Configuration capture, element count and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num   <= '0;
            r_bias  <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_num   <= num_elems;
                r_bias  <= bias;
                r_shift <= shift;
                r_relu  <= relu_en;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
            // A dropped beat outranks the clear from a simultaneous start.
            if (valid_fifo_out && (r_state != ST_RUN)) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Lane insert and write decision; lanes above lane_idx are always zero.
    always_comb begin
        w_lanes = r_lanes;
        w_be    = '0;
        if (w_s2_vld) begin
            w_lanes[r_lane_idx] = w_s2_data;
        end else begin
            w_lanes = r_lanes;
        end
        for (int i = 0; i < PACK; i++) begin
            w_be[i] = (LW'(i) <= r_lane_idx);
        end
        w_full = w_s2_vld && (r_lane_idx == LAST_LANE);
        w_tail = w_s2_vld && (r_state == ST_FLUSH) && !w_s1_vld;
        w_wr   = w_full || w_tail;
    end

    // Packing register, word address and SRAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_lane_idx  <= '0;
            r_lanes     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_mem_we <= w_wr;
            if (w_start_ok) begin
                r_addr     <= base_addr;
                r_lane_idx <= '0;
                r_lanes    <= '0;
            end else if (w_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_lanes;
                r_mem_be    <= w_be;
                r_addr      <= r_addr + ADDR_ONE;
                r_lane_idx  <= '0;
                r_lanes     <= '0;
            end else if (w_s2_vld) begin
                r_lanes    <= w_lanes;
                r_lane_idx <= r_lane_idx + LANE_ONE;
            end else begin
                r_lanes    <= r_lanes;
                r_lane_idx <= r_lane_idx;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: packing, requantisation, ReLU/partial word,
// protocol errors, address wrap and mid-run reset.
module tb_psum_drain;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [11:0]        num_elems;
    logic [9:0]         base_addr;
    logic signed [24:0] bias;
    logic [4:0]         shift;
    logic               relu_en;
    logic signed [24:0] fifo_out;
    logic               valid_fifo_out;
    logic               mem_we;
    logic [9:0]         mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_be;
    logic               busy;
    logic               done;
    logic               err;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int t_start;
    int t_beat;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];
    int          wc_q[$];
    int          dc_q[$];

    psum_drain dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_elems      (num_elems),
        .base_addr      (base_addr),
        .bias           (bias),
        .shift          (shift),
        .relu_en        (relu_en),
        .fifo_out       (fifo_out),
        .valid_fifo_out (valid_fifo_out),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Cycle counter (counts rising edges).
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wb_q.push_back(mem_be);
            wc_q.push_back(cyc);
        end
        if (done === 1'b1) dc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
        wb_q.delete();
        wc_q.delete();
        dc_q.delete();
    endtask

    task automatic go(input int n, input int base, input int b, input int sh, input logic rl);
        num_elems = 12'(n);
        base_addr = 10'(base);
        bias      = 25'(b);
        shift     = 5'(sh);
        relu_en   = rl;
        start     = 1'b1;
        t_start   = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic push(input int v);
        fifo_out       = 25'(v);
        valid_fifo_out = 1'b1;
        t_beat         = cyc;
        tick();
        valid_fifo_out = 1'b0;
        fifo_out       = '0;
    endtask

    task automatic wait_done(input string t, input int budget);
        int k;
        k = 0;
        while (dc_q.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        chk({t, " done_seen"}, 64'(dc_q.size()), 64'd1);
        tick();
        tick();
    endtask

    task automatic chk_wr(input string t, input int idx, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        if (idx < wa_q.size()) begin
            chk($sformatf("%s wr%0d addr", t, idx), 64'(wa_q[idx]), 64'(a));
            chk($sformatf("%s wr%0d data", t, idx), 64'(wd_q[idx]), 64'(d));
            chk($sformatf("%s wr%0d be", t, idx), 64'(wb_q[idx]), 64'(be));
        end else begin
            chk($sformatf("%s wr%0d present", t, idx), 64'(wa_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic chk_idle_outputs(input string t);
        chk({t, " mem_we"}, 64'(mem_we), 64'd0);
        chk({t, " mem_addr"}, 64'(mem_addr), 64'd0);
        chk({t, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({t, " mem_be"}, 64'(mem_be), 64'd0);
        chk({t, " busy"}, 64'(busy), 64'd0);
        chk({t, " done"}, 64'(done), 64'd0);
        chk({t, " err"}, 64'(err), 64'd0);
    endtask

    task automatic basic_pack(input string t);
        clr_log();
        go(8, 16'h10, 0, 0, 1'b0);
        chk({t, " busy_run"}, 64'(busy), 64'd1);
        for (int i = 1; i <= 8; i++) push(i);
        wait_done(t, 20);
        chk({t, " n_writes"}, 64'(wa_q.size()), 64'd2);
        chk_wr(t, 0, 10'h010, 32'h04030201, 4'hF);
        chk_wr(t, 1, 10'h011, 32'h08070605, 4'hF);
        if (wc_q.size() == 2 && dc_q.size() == 1) begin
            chk({t, " last_wr_latency"}, 64'(wc_q[1] - t_beat), 64'd3);
            chk({t, " done_after_wr"}, 64'(dc_q[0] - wc_q[1]), 64'd1);
        end else begin
            chk({t, " timing_events"}, 64'(wc_q.size() + dc_q.size()), 64'd3);
        end
        chk({t, " err"}, 64'(err), 64'd0);
        chk({t, " busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_elems = '0; base_addr = '0; bias = '0;
        shift = '0; relu_en = 1'b0; fifo_out = '0; valid_fifo_out = 1'b0;
        tick(); tick(); tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic pack of 1..8 into two words.
        basic_pack("t1");

        // Requant and saturation: 9,1000,-1000,-2 -> 2,127,-128,-1.
        clr_log();
        go(4, 0, -3, 2, 1'b0);
        push(9); push(1000); push(-1000); push(-2);
        wait_done("t2", 20);
        chk("t2 n_writes", 64'(wa_q.size()), 64'd1);
        chk_wr("t2", 0, 10'h000, 32'hFF807F02, 4'hF);

        // ReLU with a three-element partial word.
        clr_log();
        go(3, 16'h20, 0, 0, 1'b1);
        push(-50); push(20); push(-1);
        wait_done("t3", 20);
        chk("t3 n_writes", 64'(wa_q.size()), 64'd1);
        chk_wr("t3", 0, 10'h020, 32'h00001400, 4'h7);
        if (wc_q.size() == 1 && dc_q.size() == 1) begin
            chk("t3 done_after_wr", 64'(dc_q[0] - wc_q[0]), 64'd1);
        end else begin
            chk("t3 timing_events", 64'(wc_q.size() + dc_q.size()), 64'd2);
        end
        chk("t3 err", 64'(err), 64'd0);

        // Protocol errors.
        clr_log();
        push(5);
        chk("t4 err_idle_beat", 64'(err), 64'd1);
        tick(); tick(); tick();
        chk("t4 no_write_idle", 64'(wa_q.size()), 64'd0);
        go(0, 16'h30, 0, 0, 1'b0);
        chk("t4 err_cleared", 64'(err), 64'd0);
        wait_done("t4a", 5);
        if (dc_q.size() == 1) chk("t4 zero_done_cycle", 64'(dc_q[0] - t_start), 64'd1);
        chk("t4 zero_no_write", 64'(wa_q.size()), 64'd0);
        clr_log();
        start = 1'b1; valid_fifo_out = 1'b1; fifo_out = 25'sd7; num_elems = '0;
        tick();
        start = 1'b0; valid_fifo_out = 1'b0;
        chk("t4 err_start_and_beat", 64'(err), 64'd1);
        wait_done("t4b", 5);
        chk("t4b no_write", 64'(wa_q.size()), 64'd0);
        // Extra beat after the last element is dropped and flagged.
        clr_log();
        go(2, 16'h40, 0, 0, 1'b0);
        push(3); push(4); push(99);
        wait_done("t4c", 20);
        chk("t4 err_extra_beat", 64'(err), 64'd1);
        chk("t4c n_writes", 64'(wa_q.size()), 64'd1);
        chk_wr("t4c", 0, 10'h040, 32'h00000403, 4'h3);

        // Gapped input with address wrap.
        clr_log();
        go(8, 16'h3FF, 0, 0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            push(i);
            if (i % 3 == 1) begin
                tick(); tick();
            end
        end
        wait_done("t5", 30);
        chk("t5 n_writes", 64'(wa_q.size()), 64'd2);
        chk_wr("t5", 0, 10'h3FF, 32'h04030201, 4'hF);
        chk_wr("t5", 1, 10'h000, 32'h08070605, 4'hF);
        chk("t5 err", 64'(err), 64'd0);

        // Reset after two of four elements.
        clr_log();
        go(4, 16'h50, 0, 0, 1'b0);
        push(1); push(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("t6_rst");
        for (int i = 0; i < 6; i++) tick();
        chk("t6 no_write", 64'(wa_q.size()), 64'd0);
        chk("t6 no_done", 64'(dc_q.size()), 64'd0);
        basic_pack("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
